// File: rtl/ip_stream_convert.sv
// Streaming input converter for the R2SDF FFT front-end: raw signed samples are
// shifted and saturated into fixed point, buffered, and framed with SOF/EOF markers.
module ip_stream_convert #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 32,
    parameter int FRAC_BITS  = 16,
    parameter int LENGTH     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic [15:0]      frame_cnt,
    output logic             sat_flag,
    input  logic             sat_clr
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = $clog2(LENGTH);
    localparam int FULL_W = IN_W + FRAC_BITS;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    logic [OUT_W-1:0] w_conv;
    logic             w_sat;
    logic             w_push;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Sample conversion (combinational on in_data)
    // ------------------------------------------------------------------
    if (MODE == 0) begin : g_fixed
        logic signed [FULL_W-1:0] w_full;
        assign w_full = FULL_W'($signed(in_data)) <<< FRAC_BITS;

        if (FULL_W > OUT_W) begin : g_clamp
            // The value fits only if every bit above the output sign bit matches it.
            logic [FULL_W-OUT_W:0] w_top;
            assign w_top  = w_full[FULL_W-1:OUT_W-1];
            assign w_sat  = !((&w_top) || !(|w_top));
            assign w_conv = !w_sat ? w_full[OUT_W-1:0] :
                            w_full[FULL_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                             : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin : g_extend
            assign w_sat  = 1'b0;
            assign w_conv = OUT_W'(w_full);
        end
    end else begin : g_pass
        assign w_sat = 1'b0;
        if (IN_W > OUT_W) begin : g_trunc
            assign w_conv = in_data[OUT_W-1:0];
        end else begin : g_sext
            assign w_conv = OUT_W'($signed(in_data));
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    assign in_ready  = (r_count < DEPTH_C);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

    // NOTE: the storage array has no reset; out_valid gates every read, so stale
    // contents are never observed and the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_conv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame tracking and sticky saturation flag
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_frame_cnt;
    logic             r_sat_flag;

    assign out_sof   = out_valid && (r_idx == '0);
    assign out_eof   = out_valid && (r_idx == LAST_IDX);
    assign frame_cnt = r_frame_cnt;
    assign sat_flag  = r_sat_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_sat_flag  <= 1'b0;
        end else begin
            if (w_pop) begin
                if (r_idx == LAST_IDX) begin
                    r_idx       <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            // A saturating push takes priority over a simultaneous clear.
            if (w_push && w_sat) begin
                r_sat_flag <= 1'b1;
            end else if (sat_clr) begin
                r_sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ip_stream_convert.sv
// Self-checking bench for ip_stream_convert: a queue-based reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_ip_stream_convert;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        out_sof;
    logic        out_eof;
    logic [15:0] frame_cnt;
    logic        sat_flag;
    logic        sat_clr;

    logic        in_valid2;
    logic [15:0] in_data2;
    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic        out_ready2;
    logic        out_sof2;
    logic        out_eof2;
    logic [15:0] frame_cnt2;
    logic        sat_flag2;
    logic        sat_clr2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ip_stream_convert dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .frame_cnt(frame_cnt),
        .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    ip_stream_convert #(.IN_W(16), .OUT_W(32), .MODE(1)) dut_pass (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
        .out_sof(out_sof2), .out_eof(out_eof2), .frame_cnt(frame_cnt2),
        .sat_flag(sat_flag2), .sat_clr(sat_clr2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: fixed-point value with plain integer arithmetic and clamping.
    function automatic logic [31:0] conv_fixed(input logic [31:0] d, output bit sat);
        longint v;
        v   = longint'($signed(d)) * 64'sd65536;
        sat = 1'b0;
        if (v > 64'sd2147483647) begin
            v = 64'sd2147483647; sat = 1'b1;
        end else if (v < -64'sd2147483648) begin
            v = -64'sd2147483648; sat = 1'b1;
        end
        return v[31:0];
    endfunction

    logic [31:0] exp_q[$];
    logic [31:0] popped[$];
    int unsigned m_idx;
    int unsigned m_frames;
    bit          m_sat;
    bit          m_push, m_pop, m_s;
    logic [31:0] m_c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_idx = 0; m_frames = 0; m_sat = 1'b0;
        end else begin
            m_pop  = (exp_q.size() != 0) && out_ready;
            m_push = in_valid && (exp_q.size() < 4);
            if (m_pop) begin
                void'(exp_q.pop_front());
                if (m_idx == 7) begin
                    m_idx = 0;
                    m_frames = (m_frames + 1) % 65536;
                end else begin
                    m_idx++;
                end
            end
            m_s = 1'b0;
            if (m_push) begin
                m_c = conv_fixed(in_data, m_s);
                exp_q.push_back(m_c);
            end
            if (m_push && m_s) m_sat = 1'b1;
            else if (sat_clr)  m_sat = 1'b0;
        end
    end

    // Compare process: outputs against the model every cycle, mid-period.
    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'(exp_q.size() < 4));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("out_data", 64'(out_data), 64'(exp_q[0]));
            check("out_sof", 64'(out_sof), 64'(m_idx == 0));
            check("out_eof", 64'(out_eof), 64'(m_idx == 7));
            if (out_ready && out_valid) popped.push_back(out_data);
        end else begin
            check("out_sof_idle", 64'(out_sof), 64'h0);
            check("out_eof_idle", 64'(out_eof), 64'h0);
        end
        check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
        check("sat_flag", 64'(sat_flag), 64'(m_sat));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_sof", 64'(out_sof), 64'h0);
        check("rst_eof", 64'(out_eof), 64'h0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'h0);
        check("rst_sat_flag", 64'(sat_flag), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
    endtask

    logic [31:0] bp_exp [5] = '{32'h000A0000, 32'h000B0000, 32'h000C0000,
                                32'h000D0000, 32'h000E0000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit accepted;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sat_clr = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1; sat_clr2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        cyc();

        // Basic conversion, one cycle latency, including the largest non-saturating value.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'd3;
        cyc();
        check("conv_3", 64'(out_data), 64'h00030000);
        check("conv_3_valid", 64'(out_valid), 64'h1);
        in_data = 32'hFFFFFFFF;
        cyc();
        check("conv_m1", 64'(out_data), 64'hFFFF0000);
        in_data = 32'h00007FFF;
        cyc();
        check("conv_max_nosat", 64'(out_data), 64'h7FFF0000);
        in_valid = 1'b0;
        cyc();
        check("no_sat_yet", 64'(sat_flag), 64'h0);
        check("drained", 64'(out_valid), 64'h0);

        // Saturation on both rails, then clear, then set-wins-over-clear.
        in_valid = 1'b1; in_data = 32'h00008000;
        cyc();
        check("sat_pos", 64'(out_data), 64'h7FFFFFFF);
        check("sat_flag_set", 64'(sat_flag), 64'h1);
        in_data = 32'hFFFF7FFF;
        cyc();
        check("sat_neg", 64'(out_data), 64'h80000000);
        in_valid = 1'b0;
        cyc();
        check("sat_sticky", 64'(sat_flag), 64'h1);
        sat_clr = 1'b1;
        cyc();
        sat_clr = 1'b0;
        check("sat_cleared", 64'(sat_flag), 64'h0);
        sat_clr = 1'b1; in_valid = 1'b1; in_data = 32'h00010000;
        cyc();
        check("sat_set_wins", 64'(sat_flag), 64'h1);
        sat_clr = 1'b0; in_valid = 1'b0;
        cyc();

        // Backpressure: fill the FIFO, hold a fifth sample, then drain in order.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 32'(10 + k);
            cyc();
        end
        check("bp_full_not_ready", 64'(in_ready), 64'h0);
        check("bp_head", 64'(out_data), 64'h000A0000);
        in_data = 32'd14;
        cyc();
        cyc();
        check("bp_held_not_ready", 64'(in_ready), 64'h0);
        check("bp_head_stable", 64'(out_data), 64'h000A0000);
        popped.delete();
        out_ready = 1'b1;
        accepted = 1'b0;
        for (int t = 0; t < 10 && !accepted; t++) begin
            accepted = in_ready;
            cyc();
        end
        check("bp_fifth_accepted", 64'(accepted), 64'h1);
        in_valid = 1'b0;
        for (int t = 0; t < 10 && out_valid; t++) cyc();
        check("bp_count", 64'(popped.size()), 64'd5);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            check("bp_order", 64'(popped[i]), 64'(bp_exp[i]));

        // Framing: 16 continuous samples from a clean reset.
        rst = 1'b1;
        cyc();
        check_reset_state();
        rst = 1'b0;
        cyc();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 32'(k + 1);
            cyc();
            check("frm_data", 64'(out_data), 64'(32'(k + 1) << 16));
            check("frm_sof", 64'(out_sof), 64'(k % 8 == 0));
            check("frm_eof", 64'(out_eof), 64'(k % 8 == 7));
            check("frm_cnt", 64'(frame_cnt), 64'(k / 8));
        end
        in_valid = 1'b0;
        cyc();
        check("frm_cnt_final", 64'(frame_cnt), 64'd2);

        // Reset mid-frame with two samples buffered.
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 32'(k);
            cyc();
        end
        out_ready = 1'b0; in_data = 32'd6;
        cyc();
        in_valid = 1'b0;
        check("mid_valid", 64'(out_valid), 64'h1);
        check("mid_frames", 64'(frame_cnt), 64'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_frames", 64'(frame_cnt), 64'h0);
        cyc();
        rst = 1'b0;
        cyc();
        in_valid = 1'b1; in_data = 32'h21; out_ready = 1'b1;
        cyc();
        check("post_rst_sof", 64'(out_sof), 64'h1);
        check("post_rst_data", 64'(out_data), 64'h00210000);
        in_valid = 1'b0;
        cyc();

        // Passthrough instance: sign extension, no saturation.
        in_valid2 = 1'b1; in_data2 = 16'h8001;
        cyc();
        check("pass_8001", 64'(out_data2), 64'hFFFF8001);
        check("pass_valid", 64'(out_valid2), 64'h1);
        check("pass_sof", 64'(out_sof2), 64'h1);
        in_data2 = 16'h7FFF;
        cyc();
        check("pass_7fff", 64'(out_data2), 64'h00007FFF);
        check("pass_eof", 64'(out_eof2), 64'h0);
        in_data2 = 16'hFFFF;
        cyc();
        check("pass_ffff", 64'(out_data2), 64'hFFFFFFFF);
        in_valid2 = 1'b0;
        cyc();
        check("pass_no_sat", 64'(sat_flag2), 64'h0);
        check("pass_drained", 64'(out_valid2), 64'h0);
        check("pass_ready", 64'(in_ready2), 64'h1);
        check("pass_frames", 64'(frame_cnt2), 64'h0);

        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
